// File: rtl/piso_uart_tx.sv
// Parallel-in/serial-out UART transmit framer: builds start/data/parity/stop
// internally and shifts one bit per baud tick, LSB first, line idle high.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for a word on a tick
// SEND  | frame in flight, cnt = index of the bit currently on sdo
module piso_uart_tx #(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    output logic              sdo,
    output logic              busy,
    output logic              done
);

    localparam int PAR_W   = (PARITY != 0) ? 1 : 0;
    localparam int FRAME_W = 1 + DATA_W + PAR_W + STOP_BITS;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
            $error("piso_uart_tx: DATA_W must be in 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("piso_uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("piso_uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    logic [0:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] frame;
    logic               done_q;
    logic               last_bit;
    logic               accept;

    generate
        if (PARITY == 0) begin : g_no_parity
            assign frame = {{STOP_BITS{1'b1}}, din, 1'b0};
        end else begin : g_parity
            logic par_bit;
            // odd parity is the inverse of the even-parity XOR
            assign par_bit = (^din) ^ (PARITY == 2);
            assign frame   = {{STOP_BITS{1'b1}}, par_bit, din, 1'b0};
        end
    endgenerate

    assign last_bit  = (state == SEND) && (cnt == LAST);
    assign din_ready = tick & ((state == IDLE) | last_bit);
    assign accept    = din_valid & din_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg  <= '1;
            cnt    <= '0;
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // back-to-back load on the final tick still reports completion
                shreg  <= frame;
                cnt    <= '0;
                state  <= SEND;
                done_q <= last_bit;
            end else if (state == SEND && tick) begin
                shreg <= {1'b1, shreg[FRAME_W-1:1]};
                if (last_bit) begin
                    cnt    <= '0;
                    state  <= IDLE;
                    done_q <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign sdo  = shreg[0];
    assign busy = (state == SEND);
    assign done = done_q;

endmodule

// File: tb/tb_piso_uart_tx.sv
// Bench for piso_uart_tx: four framings side by side, each checked every cycle
// against a queue-of-bits model, plus literal bit sequences per scenario.
module tb_piso_uart_tx;

    localparam int NI = 4;
    localparam int CFG_DW  [NI] = '{8, 8, 8, 5};
    localparam int CFG_PAR [NI] = '{0, 1, 2, 0};
    localparam int CFG_SB  [NI] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       valid [NI];
    logic [8:0] din_w [NI];
    logic       ready_w [NI];
    logic       sdo_w [NI];
    logic       busy_w [NI];
    logic       done_w [NI];

    wire        m_sdo [NI];
    wire        m_busy [NI];
    wire        m_done [NI];
    wire [31:0] m_qn [NI];

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 0;
    logic [31:0] rec_bits [NI];
    int          rec_n [NI];
    int          dn [NI];
    int          done_at [NI][4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int DW  = CFG_DW[g];
        localparam int PAR = CFG_PAR[g];
        localparam int SB  = CFG_SB[g];

        piso_uart_tx #(.DATA_W(DW), .PARITY(PAR), .STOP_BITS(SB)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .din_valid(valid[g]),
            .din      (din_w[g][DW-1:0]),
            .din_ready(ready_w[g]),
            .sdo      (sdo_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g])
        );

        // Model: the bits still to appear on the line, head = current bit.
        bit q[$];
        bit ms = 1'b1;
        bit md = 1'b0;
        int qn = 0;

        always @(posedge clk) begin
            bit         rdy;
            bit         pb;
            logic [8:0] d;
            if (!reset) begin
                q.delete();
                md = 1'b0;
            end else begin
                rdy = tick && (q.size() <= 1);
                md  = 1'b0;
                if (tick && q.size() > 0) begin
                    void'(q.pop_front());
                    if (q.size() == 0) md = 1'b1;
                end
                if (rdy && valid[g]) begin
                    d = din_w[g];
                    q.push_back(1'b0);
                    for (int i = 0; i < DW; i++) q.push_back(d[i]);
                    if (PAR != 0) begin
                        pb = ($countones(d[DW-1:0]) % 2) == 1;
                        q.push_back(pb ^ (PAR == 2));
                    end
                    for (int i = 0; i < SB; i++) q.push_back(1'b1);
                end
            end
            qn = q.size();
            ms = (qn != 0) ? q[0] : 1'b1;
        end

        assign m_sdo[g]  = ms;
        assign m_busy[g] = (qn != 0);
        assign m_done[g] = md;
        assign m_qn[g]   = qn;
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int g = 0; g < NI; g++) begin
                    check($sformatf("sdo[%0d]", g), 32'(sdo_w[g]), 32'(m_sdo[g]));
                    check($sformatf("busy[%0d]", g), 32'(busy_w[g]), 32'(m_busy[g]));
                    check($sformatf("done[%0d]", g), 32'(done_w[g]), 32'(m_done[g]));
                    check($sformatf("din_ready[%0d]", g), 32'(ready_w[g]),
                          32'(tick && (m_qn[g] <= 1)));
                    if (tick) begin
                        if (rec_n[g] < 32) rec_bits[g][rec_n[g]] = sdo_w[g];
                        rec_n[g]++;
                    end
                    if (done_w[g]) begin
                        if (dn[g] < 4) done_at[g][dn[g]] = rec_n[g];
                        dn[g]++;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic tick_period();
        tick = 1'b0;
        repeat (3) cycle();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic clear_rec();
        for (int g = 0; g < NI; g++) begin
            rec_bits[g] = '0;
            rec_n[g]    = 0;
            dn[g]       = 0;
            for (int k = 0; k < 4; k++) done_at[g][k] = -1;
        end
    endtask

    // lit is written in line order: leftmost digit is the first bit sent
    task automatic pin_seq(string nm, int g, logic [31:0] lit, int n);
        logic [31:0] e;
        logic [31:0] m;
        e = '0;
        for (int k = 0; k < n; k++) e[k] = lit[n-1-k];
        m = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
        check(nm, rec_bits[g] & m, e);
    endtask

    initial begin
        fork
            compare_loop();
        join_none

        reset = 1'b0;
        tick  = 1'b0;
        for (int g = 0; g < NI; g++) begin
            valid[g] = 1'b0;
            din_w[g] = '0;
        end
        clear_rec();
        repeat (3) cycle();
        reset = 1'b1;
        chk_en = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("reset sdo[%0d]", g), 32'(sdo_w[g]), 32'd1);
            check($sformatf("reset busy[%0d]", g), 32'(busy_w[g]), 32'd0);
        end
        cycle();

        // one frame on every framing variant at once
        din_w[0] = 9'h055;
        din_w[1] = 9'h007;
        din_w[2] = 9'h007;
        din_w[3] = 9'h01F;
        for (int g = 0; g < NI; g++) valid[g] = 1'b1;
        tick_period();
        for (int g = 0; g < NI; g++) valid[g] = 1'b0;
        clear_rec();
        repeat (12) tick_period();
        pin_seq("seq 8N1 55", 0, 32'b0101010101, 10);
        pin_seq("seq 8E1 07", 1, 32'b01110000011, 11);
        pin_seq("seq 8O1 07", 2, 32'b01110000001, 11);
        pin_seq("seq 5N2 1F", 3, 32'b01111111, 8);
        check("done tick 8N1", 32'(done_at[0][0]), 32'd10);
        check("done tick 8E1", 32'(done_at[1][0]), 32'd11);
        check("done tick 8O1", 32'(done_at[2][0]), 32'd11);
        check("done tick 5N2", 32'(done_at[3][0]), 32'd8);
        check("done count 8N1", 32'(dn[0]), 32'd1);

        // back-to-back frames with valid held
        valid[0] = 1'b1;
        din_w[0] = 9'h0A3;
        tick_period();
        clear_rec();
        din_w[0] = 9'h03C;
        repeat (10) tick_period();
        valid[0] = 1'b0;
        repeat (12) tick_period();
        pin_seq("seq b2b", 0, 32'b01100010110001111001, 20);
        check("b2b done1 tick", 32'(done_at[0][0]), 32'd10);
        check("b2b done2 tick", 32'(done_at[0][1]), 32'd20);
        check("b2b done count", 32'(dn[0]), 32'd2);

        // reset one cycle after the 4th tick of a frame
        valid[0] = 1'b1;
        din_w[0] = 9'h033;
        tick_period();
        valid[0] = 1'b0;
        repeat (4) tick_period();
        cycle();
        #1;
        check("pre-reset busy", 32'(busy_w[0]), 32'd1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        #1;
        check("post-reset sdo", 32'(sdo_w[0]), 32'd1);
        check("post-reset busy", 32'(busy_w[0]), 32'd0);
        check("post-reset done", 32'(done_w[0]), 32'd0);
        cycle();
        valid[0] = 1'b1;
        din_w[0] = 9'h096;
        tick_period();
        valid[0] = 1'b0;
        clear_rec();
        repeat (11) tick_period();
        pin_seq("seq after reset", 0, 32'b0011010011, 10);
        check("done after reset", 32'(done_at[0][0]), 32'd10);

        // valid waits for a tick; din changes after accept must not leak in
        valid[0] = 1'b1;
        din_w[0] = 9'h05A;
        tick = 1'b0;
        repeat (20) cycle();
        check("no-tick sdo", 32'(sdo_w[0]), 32'd1);
        check("no-tick busy", 32'(busy_w[0]), 32'd0);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        valid[0] = 1'b0;
        din_w[0] = 9'h0FF;
        clear_rec();
        repeat (11) tick_period();
        pin_seq("seq din held", 0, 32'b0010110101, 10);
        check("done din held", 32'(done_at[0][0]), 32'd10);

        repeat (4) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
